fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction memory. Holds the program counter and drives the 8-bit word address into `im`. It captures the 32-bit word `im` returns one cycle later and presents {pc, instruction} pairs to decode through a valid/ready handshake. A 2-entry output buffer with credit-based issue gives full throughput under back-pressure; a redirect input (branch/jump) flushes in-flight and buffered fetches.

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a 1-cycle-latency instruction
// memory. Holds the PC, drives it as the word address, captures the returned
// word one cycle later and queues {pc, inst} in a 2-entry buffer for decode.
// Issue is credit-limited so that buffered + in-flight entries never exceed 2;
// a redirect reloads the PC and drops both buffered and in-flight fetches.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fetch_en         allow new fetches to issue
//   redirect_valid   load redirect_pc into the PC and flush
//   redirect_pc      redirect target word address
//   addr             word address to instruction memory (always the PC)
//   inst_in          instruction memory data, valid the cycle after addr
//   inst_valid       buffer head holds an entry
//   inst_ready       decode accepts the head this cycle
//   inst_out         head instruction
//   pc_out           address the head instruction was fetched from
module fetch_unit #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  addr,
  input  logic [31:0] inst_in,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [7:0]  pc_out
);

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      fifo_q [DEPTH];
  logic [7:0]  pc_q;
  logic [7:0]  pend_pc;
  logic        pending;
  logic [1:0]  occ;
  logic        rptr, wptr;    // two entries, so one-bit pointers suffice

  logic        pop, push, issue;
  logic [2:0]  inflight;

  assign addr       = pc_q;
  assign inst_valid = (occ != 2'd0);
  assign inst_out   = fifo_q[rptr].inst;
  assign pc_out     = fifo_q[rptr].pc;

  assign pop  = inst_valid & inst_ready;
  assign push = pending & ~redirect_valid;

  // Slots that will be occupied after this edge if nothing new issues. pop is
  // only possible with occ>=1, so the subtraction never underflows. Counting
  // the pop as a freed slot is what gives one-per-cycle streaming with ready
  // held high.
  assign inflight = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
  assign issue    = fetch_en & ~redirect_valid & (inflight < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      pend_pc <= 8'd0;
      pending <= 1'b0;
      occ     <= 2'd0;
      rptr    <= 1'b0;
      wptr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (redirect_valid) begin
      // Flush: the in-flight word is never captured and the buffer is emptied.
      // A head popped this cycle is still considered delivered.
      pc_q    <= redirect_pc;
      pending <= 1'b0;
      occ     <= 2'd0;
      rptr    <= 1'b0;
      wptr    <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pend_pc <= pc_q;
        pc_q    <= pc_q + 8'd1;
      end
      if (push) begin
        fifo_q[wptr] <= '{pc: pend_pc, inst: inst_in};
        wptr         <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  addr;
  logic [31:0] inst_in = 32'd0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [7:0]  pc_out;

  int errors = 0;
  int checks = 0;
  logic [7:0] sbq[$];   // pcs decode is expected to accept, in order

  fetch_unit #(.DEPTH(2), .RESET_PC(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .addr(addr), .inst_in(inst_in), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: word[i] = i+100, except word[75] = 3000.
  function automatic logic [31:0] word(input logic [7:0] a);
    return (a == 8'd75) ? 32'd3000 : 32'(a) + 32'd100;
  endfunction

  // One-cycle read latency memory model.
  always @(posedge clk) inst_in <= word(addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Replace scoreboard contents with n consecutive pcs (mod 256) from start.
  task automatic sb_seq(input logic [7:0] start, input int n);
    logic [7:0] p;
    p = start;
    sbq.delete();
    for (int i = 0; i < n; i++) begin
      sbq.push_back(p);
      p = p + 8'd1;
    end
  endtask

  // Every accepted handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && inst_valid && inst_ready) begin
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed pc=%0d expected none", pc_out);
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_pc", {24'd0, pc_out}, {24'd0, e});
        chk("sb_inst", inst_out, word(e));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_addr", {24'd0, addr}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pc_out", {24'd0, pc_out}, 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    nxt(); nxt();

    // Streaming from reset with ready high.
    sb_seq(8'd0, 40);
    rst_n = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
    chk("c0_valid", {31'd0, inst_valid}, 32'd0);
    chk("c0_addr", {24'd0, addr}, 32'd0);
    nxt();
    chk("c1_valid", {31'd0, inst_valid}, 32'd0);
    chk("c1_addr", {24'd0, addr}, 32'd1);
    nxt();
    chk("c2_valid", {31'd0, inst_valid}, 32'd1);
    chk("c2_pc_out", {24'd0, pc_out}, 32'd0);
    chk("c2_inst_out", inst_out, 32'd100);
    nxt(); nxt(); nxt();

    // Back-pressure after pcs 0..2 accepted.
    inst_ready = 1'b0;
    chk("bp_addr", {24'd0, addr}, 32'd5);
    chk("bp_pc_out", {24'd0, pc_out}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("bp_hold_addr", {24'd0, addr}, 32'd5);
      chk("bp_hold_pc", {24'd0, pc_out}, 32'd3);
      chk("bp_hold_valid", {31'd0, inst_valid}, 32'd1);
    end
    nxt();
    inst_ready = 1'b1;
    chk("rel_pc3", {24'd0, pc_out}, 32'd3);
    nxt();
    chk("rel_pc4", {24'd0, pc_out}, 32'd4);
    chk("rel_v4", {31'd0, inst_valid}, 32'd1);
    nxt();
    chk("rel_pc5", {24'd0, pc_out}, 32'd5);
    chk("rel_v5", {31'd0, inst_valid}, 32'd1);

    // Fill the buffer, then redirect to 75.
    nxt();
    inst_ready = 1'b0;
    nxt();
    redirect_valid = 1'b1; redirect_pc = 8'd75;
    chk("full_pc", {24'd0, pc_out}, 32'd6);
    chk("full_valid", {31'd0, inst_valid}, 32'd1);
    nxt();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    sb_seq(8'd75, 40);
    chk("rd_v1", {31'd0, inst_valid}, 32'd0);
    nxt();
    chk("rd_v2", {31'd0, inst_valid}, 32'd0);
    nxt();
    chk("rd_v3", {31'd0, inst_valid}, 32'd1);
    chk("rd_pc", {24'd0, pc_out}, 32'd75);
    chk("rd_inst", inst_out, 32'd3000);
    nxt(); nxt(); nxt();

    // Redirect to 254 while the head (78) is popped in the same cycle.
    chk("rp_head", {24'd0, pc_out}, 32'd78);
    redirect_valid = 1'b1; redirect_pc = 8'd254;
    nxt();
    redirect_valid = 1'b0;
    sb_seq(8'd254, 40);
    chk("wr_v1", {31'd0, inst_valid}, 32'd0);
    nxt();
    chk("wr_v2", {31'd0, inst_valid}, 32'd0);
    nxt(); chk("wr_254", {24'd0, pc_out}, 32'd254);
    nxt(); chk("wr_255", {24'd0, pc_out}, 32'd255);
    nxt(); chk("wr_0", {24'd0, pc_out}, 32'd0);
    nxt(); chk("wr_1", {24'd0, pc_out}, 32'd1);

    // Back-to-back redirects: 10 then 20.
    nxt();
    chk("bb_head", {24'd0, pc_out}, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 8'd10;
    nxt();
    redirect_pc = 8'd20;
    sb_seq(8'd10, 40);
    chk("bb_v0", {31'd0, inst_valid}, 32'd0);
    nxt();
    redirect_valid = 1'b0;
    sb_seq(8'd20, 40);
    chk("bb_v1", {31'd0, inst_valid}, 32'd0);
    nxt();
    chk("bb_v2", {31'd0, inst_valid}, 32'd0);
    nxt();
    chk("bb_v3", {31'd0, inst_valid}, 32'd1);
    chk("bb_pc20", {24'd0, pc_out}, 32'd20);
    nxt();
    chk("bb_pc21", {24'd0, pc_out}, 32'd21);
    nxt(); nxt();

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mrst_addr", {24'd0, addr}, 32'd0);
    chk("mrst_pc_out", {24'd0, pc_out}, 32'd0);
    chk("mrst_inst_out", inst_out, 32'd0);
    sb_seq(8'd0, 40);
    nxt(); nxt();
    rst_n = 1'b1;
    chk("rs_addr", {24'd0, addr}, 32'd0);
    nxt(); nxt();
    chk("rs_valid", {31'd0, inst_valid}, 32'd1);
    chk("rs_pc0", {24'd0, pc_out}, 32'd0);
    chk("rs_inst0", inst_out, 32'd100);
    nxt(); nxt(); nxt();

    // fetch_en low: in-flight fetch completes, PC holds.
    fetch_en = 1'b0;
    chk("fe_addr", {24'd0, addr}, 32'd5);
    chk("fe_pc3", {24'd0, pc_out}, 32'd3);
    nxt();
    chk("fe_addr_hold", {24'd0, addr}, 32'd5);
    chk("fe_pc4", {24'd0, pc_out}, 32'd4);
    chk("fe_v4", {31'd0, inst_valid}, 32'd1);
    nxt();
    chk("fe_drain", {31'd0, inst_valid}, 32'd0);
    chk("fe_addr_end", {24'd0, addr}, 32'd5);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
